// File: rtl/timers_sfr_regs.sv
// SFR-side register file for the EMC08 timers: TCON, TMOD and the 24-bit count registers of
// Timer 0/1. Counts follow the timer every machine cycle, and a TL read snapshots TH/TM.
module timers_sfr_regs (
   input  logic       timers_sfr_machine_cycle_i,
   input  logic       timers_sfr_reset_i,
   input  logic [7:0] timers_sfr_addr_i,
   input  logic [7:0] timers_sfr_wdata_i,
   input  logic       timers_sfr_we_i,
   input  logic       timers_sfr_re_i,
   output logic [7:0] timers_sfr_rdata_o,
   output logic       timers_sfr_hit_o,
   input  logic       timers_sfr_int0_i,
   input  logic       timers_sfr_int1_i,
   input  logic       timers_sfr_irq_ack_t0_i,
   input  logic       timers_sfr_irq_ack_t1_i,
   input  logic       timers_sfr_irq_ack_ie0_i,
   input  logic       timers_sfr_irq_ack_ie1_i,
   output logic       timers_sfr_irq_t0_o,
   output logic       timers_sfr_irq_t1_o,
   output logic       timers_sfr_irq_ie0_o,
   output logic       timers_sfr_irq_ie1_o,
   output logic [7:0] timers_sfr_tmod_o,
   output logic       timers_sfr_tr0_o,
   output logic       timers_sfr_tr1_o,
   output logic [7:0] timers_sfr_th0_o,
   output logic [7:0] timers_sfr_tm0_o,
   output logic [7:0] timers_sfr_tl0_o,
   output logic [7:0] timers_sfr_th1_o,
   output logic [7:0] timers_sfr_tm1_o,
   output logic [7:0] timers_sfr_tl1_o,
   output logic       timers_sfr_tf0_o,
   output logic       timers_sfr_tf1_o,
   input  logic [7:0] timers_sfr_th0_i,
   input  logic [7:0] timers_sfr_tm0_i,
   input  logic [7:0] timers_sfr_tl0_i,
   input  logic [7:0] timers_sfr_th1_i,
   input  logic [7:0] timers_sfr_tm1_i,
   input  logic [7:0] timers_sfr_tl1_i,
   input  logic       timers_sfr_tf0_i,
   input  logic       timers_sfr_tf1_i
);
   localparam logic [7:0] ADDR_TCON = 8'h88;
   localparam logic [7:0] ADDR_TMOD = 8'h89;
   localparam logic [7:0] ADDR_TL0  = 8'h8A;
   localparam logic [7:0] ADDR_TH0  = 8'h8C;
   localparam logic [7:0] ADDR_TM0  = 8'h8E;

   logic [1:0][7:0] th_i, tm_i, tl_i;
   logic [1:0]      tf_i, int_i, ack_t, ack_ie;

   assign th_i   = {timers_sfr_th1_i, timers_sfr_th0_i};
   assign tm_i   = {timers_sfr_tm1_i, timers_sfr_tm0_i};
   assign tl_i   = {timers_sfr_tl1_i, timers_sfr_tl0_i};
   assign tf_i   = {timers_sfr_tf1_i, timers_sfr_tf0_i};
   assign int_i  = {timers_sfr_int1_i, timers_sfr_int0_i};
   assign ack_t  = {timers_sfr_irq_ack_t1_i, timers_sfr_irq_ack_t0_i};
   assign ack_ie = {timers_sfr_irq_ack_ie1_i, timers_sfr_irq_ack_ie0_i};

   logic [7:0]      tcon_q, tcon_d, tmod_q, tmod_d, rdata_q, rdata_d, rd_val;
   logic [1:0][7:0] th_q, th_d, tm_q, tm_d, tl_q, tl_d;
   logic [1:0][7:0] sh_th_q, sh_th_d, sh_tm_q, sh_tm_d;
   logic [1:0]      sh_vld_q, sh_vld_d, int_prev_q, int_prev_d;
   logic            wr_tl, wr_th, wr_tm, rd_tl, rd_th, rd_tm, fall;

   // All eight SFRs live in 0x88..0x8F.
   assign timers_sfr_hit_o = (timers_sfr_addr_i[7:3] == 5'b10001);

   always_comb begin
      tcon_d     = tcon_q;
      tmod_d     = tmod_q;
      sh_th_d    = sh_th_q;
      sh_tm_d    = sh_tm_q;
      sh_vld_d   = sh_vld_q;
      int_prev_d = int_i;
      th_d       = th_i;
      tm_d       = tm_i;
      tl_d       = tl_i;
      wr_tl = 1'b0; wr_th = 1'b0; wr_tm = 1'b0;
      rd_tl = 1'b0; rd_th = 1'b0; rd_tm = 1'b0;
      fall  = 1'b0;
      rd_val = 8'h00;
      if (timers_sfr_addr_i == ADDR_TCON) rd_val = tcon_q;
      if (timers_sfr_addr_i == ADDR_TMOD) rd_val = tmod_q;

      for (int n = 0; n < 2; n++) begin
         wr_tl = timers_sfr_we_i && (timers_sfr_addr_i == (ADDR_TL0 | 8'(n)));
         wr_th = timers_sfr_we_i && (timers_sfr_addr_i == (ADDR_TH0 | 8'(n)));
         wr_tm = timers_sfr_we_i && (timers_sfr_addr_i == (ADDR_TM0 | 8'(n)));
         rd_tl = timers_sfr_re_i && (timers_sfr_addr_i == (ADDR_TL0 | 8'(n)));
         rd_th = timers_sfr_re_i && (timers_sfr_addr_i == (ADDR_TH0 | 8'(n)));
         rd_tm = timers_sfr_re_i && (timers_sfr_addr_i == (ADDR_TM0 | 8'(n)));

         if (wr_tl) tl_d[n] = timers_sfr_wdata_i;
         if (wr_th) th_d[n] = timers_sfr_wdata_i;
         if (wr_tm) tm_d[n] = timers_sfr_wdata_i;

         if (timers_sfr_addr_i == (ADDR_TL0 | 8'(n))) rd_val = tl_q[n];
         if (timers_sfr_addr_i == (ADDR_TH0 | 8'(n))) rd_val = sh_vld_q[n] ? sh_th_q[n] : th_q[n];
         if (timers_sfr_addr_i == (ADDR_TM0 | 8'(n))) rd_val = sh_vld_q[n] ? sh_tm_q[n] : tm_q[n];

         // Snapshot on TL read; TH read ends the sequence; any count write invalidates it.
         if (rd_tl) begin
            sh_vld_d[n] = 1'b1;
            sh_th_d[n]  = th_q[n];
            sh_tm_d[n]  = tm_q[n];
         end
         if (rd_th) sh_vld_d[n] = 1'b0;
         if (wr_tl || wr_th || wr_tm) sh_vld_d[n] = 1'b0;

         // TF: overflow beats ack.
         tcon_d[2*n+5] = tf_i[n] ? 1'b1 : (ack_t[n] ? 1'b0 : tf_i[n]);
         fall = int_prev_q[n] & ~int_i[n];
         if (tcon_q[2*n])
            tcon_d[2*n+1] = fall | (tcon_q[2*n+1] & ~ack_ie[n]);
         else
            tcon_d[2*n+1] = ~int_i[n];
      end

      if (timers_sfr_we_i && timers_sfr_addr_i == ADDR_TCON) tcon_d = timers_sfr_wdata_i;
      if (timers_sfr_we_i && timers_sfr_addr_i == ADDR_TMOD) tmod_d = timers_sfr_wdata_i;
      rdata_d = timers_sfr_re_i ? rd_val : rdata_q;
   end

   always_ff @(posedge timers_sfr_machine_cycle_i) begin
      if (timers_sfr_reset_i) begin
         tcon_q     <= '0;
         tmod_q     <= '0;
         rdata_q    <= '0;
         th_q       <= '0;
         tm_q       <= '0;
         tl_q       <= '0;
         sh_th_q    <= '0;
         sh_tm_q    <= '0;
         sh_vld_q   <= '0;
         int_prev_q <= 2'b11;
      end else begin
         tcon_q     <= tcon_d;
         tmod_q     <= tmod_d;
         rdata_q    <= rdata_d;
         th_q       <= th_d;
         tm_q       <= tm_d;
         tl_q       <= tl_d;
         sh_th_q    <= sh_th_d;
         sh_tm_q    <= sh_tm_d;
         sh_vld_q   <= sh_vld_d;
         int_prev_q <= int_prev_d;
      end
   end

   assign timers_sfr_rdata_o   = rdata_q;
   assign timers_sfr_tmod_o    = tmod_q;
   assign timers_sfr_irq_t1_o  = tcon_q[7];
   assign timers_sfr_tr1_o     = tcon_q[6];
   assign timers_sfr_irq_t0_o  = tcon_q[5];
   assign timers_sfr_tr0_o     = tcon_q[4];
   assign timers_sfr_irq_ie1_o = tcon_q[3];
   assign timers_sfr_irq_ie0_o = tcon_q[1];
   assign timers_sfr_tf1_o     = tcon_q[7];
   assign timers_sfr_tf0_o     = tcon_q[5];
   assign timers_sfr_th0_o     = th_q[0];
   assign timers_sfr_tm0_o     = tm_q[0];
   assign timers_sfr_tl0_o     = tl_q[0];
   assign timers_sfr_th1_o     = th_q[1];
   assign timers_sfr_tm1_o     = tm_q[1];
   assign timers_sfr_tl1_o     = tl_q[1];
endmodule

// File: tb/tb_timers_sfr_regs.sv
// Scoreboard bench for timers_sfr_regs: stimulus queues expectations, a negedge monitor compares.
module tb_timers_sfr_regs;
   logic       clk = 1'b0, rst;
   logic [7:0] addr, wdata, rdata, tmod_o;
   logic       we, re, hit, int0, int1, ack_t0, ack_t1, ack_ie0, ack_ie1;
   logic       irq_t0, irq_t1, irq_ie0, irq_ie1, tr0, tr1, tf0_o, tf1_o, tf0_i, tf1_i;
   logic [7:0] th0_o, tm0_o, tl0_o, th1_o, tm1_o, tl1_o;
   logic [7:0] th0_i, tm0_i, tl0_i, th1_i, tm1_i, tl1_i;

   always #5 clk = ~clk;

   timers_sfr_regs dut (
      .timers_sfr_machine_cycle_i(clk), .timers_sfr_reset_i(rst),
      .timers_sfr_addr_i(addr), .timers_sfr_wdata_i(wdata),
      .timers_sfr_we_i(we), .timers_sfr_re_i(re),
      .timers_sfr_rdata_o(rdata), .timers_sfr_hit_o(hit),
      .timers_sfr_int0_i(int0), .timers_sfr_int1_i(int1),
      .timers_sfr_irq_ack_t0_i(ack_t0), .timers_sfr_irq_ack_t1_i(ack_t1),
      .timers_sfr_irq_ack_ie0_i(ack_ie0), .timers_sfr_irq_ack_ie1_i(ack_ie1),
      .timers_sfr_irq_t0_o(irq_t0), .timers_sfr_irq_t1_o(irq_t1),
      .timers_sfr_irq_ie0_o(irq_ie0), .timers_sfr_irq_ie1_o(irq_ie1),
      .timers_sfr_tmod_o(tmod_o), .timers_sfr_tr0_o(tr0), .timers_sfr_tr1_o(tr1),
      .timers_sfr_th0_o(th0_o), .timers_sfr_tm0_o(tm0_o), .timers_sfr_tl0_o(tl0_o),
      .timers_sfr_th1_o(th1_o), .timers_sfr_tm1_o(tm1_o), .timers_sfr_tl1_o(tl1_o),
      .timers_sfr_tf0_o(tf0_o), .timers_sfr_tf1_o(tf1_o),
      .timers_sfr_th0_i(th0_i), .timers_sfr_tm0_i(tm0_i), .timers_sfr_tl0_i(tl0_i),
      .timers_sfr_th1_i(th1_i), .timers_sfr_tm1_i(tm1_i), .timers_sfr_tl1_i(tl1_i),
      .timers_sfr_tf0_i(tf0_i), .timers_sfr_tf1_i(tf1_i)
   );

   localparam logic [7:0] A_TCON = 8'h88, A_TMOD = 8'h89, A_TL0 = 8'h8A, A_TH0 = 8'h8C, A_TM0 = 8'h8E;

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] exp;
   } chk_t;

   chk_t rd_q[$];
   chk_t chk_q[$];
   int   n_assert = 0, n_fail = 0;
   logic probe = 1'b0, rd_vld = 1'b0;

   // Read data is presented the cycle after an accepted read strobe.
   always @(posedge clk) rd_vld <= re & ~rst;

   function automatic logic [7:0] sig_val(int sel);
      case (sel)
         0: return tmod_o;
         1: return tl0_o;
         2: return tm0_o;
         3: return th0_o;
         4: return {7'b0, irq_t0};
         5: return {7'b0, irq_ie0};
         6: return {7'b0, irq_ie1};
         7: return {6'b0, tr1, tr0};
         8: return {7'b0, hit};
         9: return tmod_o | th0_o | tm0_o | tl0_o | th1_o | tm1_o | tl1_o | rdata |
                   {irq_t0, irq_t1, irq_ie0, irq_ie1, tr0, tr1, tf0_o, tf1_o};
         default: return 8'hXX;
      endcase
   endfunction

   always @(negedge clk) begin
      chk_t c;
      if (rd_vld) begin
         n_assert++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rdata_unexpected: got %h with no read pending", rdata);
         end else begin
            c = rd_q.pop_front();
            if (rdata !== c.exp) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", c.name, rdata, c.exp);
            end
         end
      end
      if (probe) begin
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_assert++;
            if (sig_val(c.sel) !== c.exp) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", c.name, sig_val(c.sel), c.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
      re = 1'b1; addr = a;
      rd_q.push_back('{nm, 0, e});
      tick();
      re = 1'b0;
   endtask

   task automatic expect_sig(input int sel, input logic [7:0] e, input string nm);
      chk_q.push_back('{nm, sel, e});
   endtask

   // Compare pending signal expectations at the next falling edge.
   task automatic probe_now();
      probe = 1'b1;
      @(negedge clk); #1;
      probe = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; re = 1'b0; addr = 8'h00; wdata = 8'h00;
      int0 = 1'b1; int1 = 1'b1; ack_t0 = 1'b0; ack_t1 = 1'b0; ack_ie0 = 1'b0; ack_ie1 = 1'b0;
      tf0_i = 1'b0; tf1_i = 1'b0;
      th0_i = 8'h00; tm0_i = 8'h00; tl0_i = 8'h00; th1_i = 8'h00; tm1_i = 8'h00; tl1_i = 8'h00;

      // Reset held while everything toggles
      for (int i = 0; i < 4; i++) begin
         we = 1'b1; re = 1'b1; addr = (i % 2 == 0) ? A_TCON : A_TL0; wdata = 8'hFF;
         th0_i = 8'($urandom); tm0_i = 8'($urandom); tl0_i = 8'($urandom);
         th1_i = 8'($urandom); tm1_i = 8'($urandom); tl1_i = 8'($urandom);
         int0 = i[0]; int1 = ~i[0]; tf0_i = 1'b1; tf1_i = 1'b1;
         ack_t0 = i[0]; ack_t1 = i[0]; ack_ie0 = ~i[0]; ack_ie1 = ~i[0];
         tick();
      end
      we = 1'b0; re = 1'b0; addr = 8'h00; wdata = 8'h00;
      th0_i = 8'h00; tm0_i = 8'h00; tl0_i = 8'h00; th1_i = 8'h00; tm1_i = 8'h00; tl1_i = 8'h00;
      int0 = 1'b1; int1 = 1'b1; tf0_i = 1'b0; tf1_i = 1'b0;
      ack_t0 = 1'b0; ack_t1 = 1'b0; ack_ie0 = 1'b0; ack_ie1 = 1'b0;
      tick();
      expect_sig(9, 8'h00, "reset_outputs");
      probe_now();
      rst = 1'b0;
      rd(A_TCON, 8'h00, "tcon_after_reset");

      // TMOD write/read and mapping
      wr(A_TMOD, 8'hA5);
      rd(A_TMOD, 8'hA5, "tmod_read");
      expect_sig(0, 8'hA5, "tmod_o");
      probe_now();

      // Address decode and undecoded read
      addr = 8'h8F; expect_sig(8, 8'h01, "hit_8f"); probe_now();
      addr = 8'h87; expect_sig(8, 8'h00, "hit_87"); probe_now();
      rd(8'h90, 8'h00, "undecoded_read");

      // TCON: TR0 + IT0
      wr(A_TCON, 8'h11);
      rd(A_TCON, 8'h11, "tcon_read");
      expect_sig(7, 8'h01, "tr_bits");
      probe_now();

      // CPU write beats timer capture on the written byte only
      th0_i = 8'h12; tm0_i = 8'h34; tl0_i = 8'h10;
      wr(A_TL0, 8'h55);
      expect_sig(1, 8'h55, "tl0_write_wins");
      expect_sig(2, 8'h34, "tm0_capture");
      expect_sig(3, 8'h12, "th0_capture");
      probe_now();

      // Coherent 24-bit read across a rollover 0x01FFFF -> 0x020000
      th0_i = 8'h01; tm0_i = 8'hFF; tl0_i = 8'hFF;
      tick();
      rd(A_TL0, 8'hFF, "coh_tl0");
      th0_i = 8'h02; tm0_i = 8'h00; tl0_i = 8'h00;
      tick();
      rd(A_TM0, 8'hFF, "coh_tm0_shadow");
      rd(A_TH0, 8'h01, "coh_th0_shadow");
      rd(A_TH0, 8'h02, "coh_th0_live");

      // A count write invalidates the snapshot
      rd(A_TL0, 8'h00, "coh2_tl0");
      th0_i = 8'h03;
      wr(A_TM0, 8'h77);
      tick();
      rd(A_TH0, 8'h03, "th0_after_write_clear");

      // Edge mode IE0 (IT0 = 1)
      int0 = 1'b0; tick();
      expect_sig(5, 8'h01, "ie0_edge_set"); probe_now();
      tick();
      expect_sig(5, 8'h01, "ie0_held"); probe_now();
      ack_ie0 = 1'b1; tick(); ack_ie0 = 1'b0;
      expect_sig(5, 8'h00, "ie0_ack_clear"); probe_now();
      tick();
      expect_sig(5, 8'h00, "ie0_low_no_retrigger"); probe_now();
      int0 = 1'b1; tick();
      int0 = 1'b0; ack_ie0 = 1'b1; tick(); ack_ie0 = 1'b0;
      expect_sig(5, 8'h01, "ie0_set_beats_ack"); probe_now();
      ack_ie0 = 1'b1; tick(); ack_ie0 = 1'b0;

      // TF0: overflow beats ack, ack alone clears
      tf0_i = 1'b1; ack_t0 = 1'b1; tick(); tf0_i = 1'b0; ack_t0 = 1'b0;
      expect_sig(4, 8'h01, "tf0_set_beats_ack"); probe_now();
      ack_t0 = 1'b1; tick(); ack_t0 = 1'b0;
      expect_sig(4, 8'h00, "tf0_ack_clear"); probe_now();

      // Level mode IE1 (IT1 = 0)
      int0 = 1'b1;
      wr(A_TCON, 8'h00);
      int1 = 1'b0; tick();
      expect_sig(6, 8'h01, "ie1_level_set"); probe_now();
      ack_ie1 = 1'b1; tick(); ack_ie1 = 1'b0;
      expect_sig(6, 8'h01, "ie1_ack_ignored"); probe_now();
      int1 = 1'b1; tick();
      expect_sig(6, 8'h00, "ie1_level_release"); probe_now();

      for (int i = 0; i < 20 && (rd_q.size() > 0 || chk_q.size() > 0); i++) tick();
      if (rd_q.size() > 0 || chk_q.size() > 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL drain: %0d reads and %0d checks still pending, required 0", rd_q.size(), chk_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
